// File: rtl/alu_bist_pkg.sv
// Shared types and constants for the ALU built-in self-test controller:
// FSM states, LFSR/MISR polynomials and where each operand field sits in the LFSR word.
package alu_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_APPLY   = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } bist_state_e;

  localparam logic [31:0] LFSR_TAPS = 32'h0040_0007;
  localparam logic [15:0] MISR_POLY = 16'h1021;

  localparam int unsigned OPA_LSB = 0;
  localparam int unsigned OPB_LSB = 16;
  localparam int unsigned CIN_BIT = 7;
  localparam int unsigned OPC_LSB = 24;

  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return {l[30:0], 1'b0} ^ (l[31] ? LFSR_TAPS : 32'h0000_0000);
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [15:0] din);
    return {s[14:0], 1'b0} ^ (s[15] ? MISR_POLY : 16'h0000) ^ din;
  endfunction

endpackage

// File: rtl/alu_bist_ctrl_lfsr.sv
// 32-bit Galois LFSR used as the vector source; a zero seed is replaced by 1
// so the register can never lock up in the all-zero state.
module bist_lfsr32
  import alu_bist_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        step_i,
  output logic [31:0] state_o
);

  localparam logic [31:0] SEED_EFF = (SEED == 32'h0000_0000) ? 32'h0000_0001 : SEED;

  logic [31:0] lfsr_q;
  logic [31:0] lfsr_d;

  // next state: reload has priority over stepping
  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = SEED_EFF;
    end else if (step_i) begin
      lfsr_d = lfsr_step(lfsr_q);
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED_EFF;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/alu_bist_ctrl.sv
// ALU self-test controller: drives LFSR vectors into the ALU, folds each response
// into a 16-bit MISR and flags pass when the final signature matches GOLDEN_SIG.
module alu_bist_ctrl
  import alu_bist_pkg::*;
#(
  parameter int unsigned NUM_VECTORS   = 6,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter logic [31:0] SEED          = 32'h0000_0001,
  parameter logic [15:0] GOLDEN_SIG    = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic        alu_cin,
  output logic [2:0]  alu_opc,
  input  logic [15:0] alu_w,
  input  logic        alu_zer,
  input  logic        alu_neg,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] signature
);

  localparam logic [15:0] LAST_VEC    = 16'(NUM_VECTORS - 1);
  localparam logic [15:0] LAST_SETTLE = 16'(SETTLE_CYCLES - 1);

  bist_state_e state_q;
  logic [15:0] settle_q;
  logic [15:0] count_q;
  logic [15:0] sig_q;
  logic [15:0] alu_a_q;
  logic [15:0] alu_b_q;
  logic        alu_cin_q;
  logic [2:0]  alu_opc_q;
  logic        busy_q;
  logic        done_q;
  logic        pass_q;

  logic [31:0] lfsr_state;
  logic        lfsr_load;
  logic        lfsr_step_en;
  logic [15:0] din;
  logic [15:0] sig_d;

  bist_lfsr32 #(
    .SEED(SEED)
  ) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (lfsr_load),
    .step_i (lfsr_step_en),
    .state_o(lfsr_state)
  );

  // LFSR control: reload on an accepted start, step once per applied vector
  always_comb begin
    lfsr_load    = 1'b0;
    lfsr_step_en = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: lfsr_load = start;
      ST_APPLY:         lfsr_step_en = 1'b1;
      default: begin
        lfsr_load    = 1'b0;
        lfsr_step_en = 1'b0;
      end
    endcase
  end

  assign din   = alu_w ^ {14'd0, alu_neg, alu_zer};
  assign sig_d = misr_step(sig_q, din);

  // sequencer with registered ALU operands, status flags and MISR
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      settle_q  <= 16'd0;
      count_q   <= 16'd0;
      sig_q     <= 16'd0;
      alu_a_q   <= 16'd0;
      alu_b_q   <= 16'd0;
      alu_cin_q <= 1'b0;
      alu_opc_q <= 3'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q <= ST_APPLY;
            sig_q   <= 16'd0;
            count_q <= 16'd0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
          end
        end
        ST_APPLY: begin
          alu_a_q   <= lfsr_state[OPA_LSB +: 16];
          alu_b_q   <= lfsr_state[OPB_LSB +: 16];
          alu_cin_q <= lfsr_state[CIN_BIT];
          alu_opc_q <= lfsr_state[OPC_LSB +: 3];
          settle_q  <= 16'd0;
          state_q   <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_q == LAST_SETTLE) begin
            state_q <= ST_CAPTURE;
          end else begin
            settle_q <= settle_q + 16'd1;
          end
        end
        ST_CAPTURE: begin
          sig_q   <= sig_d;
          count_q <= count_q + 16'd1;
          // pass is judged on the signature being written this cycle
          if (count_q == LAST_VEC) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (sig_d == GOLDEN_SIG);
          end else begin
            state_q <= ST_APPLY;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          pass_q  <= 1'b0;
        end
      endcase
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_cin   = alu_cin_q;
  assign alu_opc   = alu_opc_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign signature = sig_q;

endmodule

// File: tb/tb_alu_bist_ctrl.sv
// Self-checking bench: a behavioural ALU/LFSR/MISR model predicts vectors and signatures
// for a 6-vector instance on a model ALU and a 2-vector instance on a driven stub ALU.
module tb_alu_bist_ctrl;

  localparam int N_A = 6;
  localparam int N_B = 2;

  function automatic logic [15:0] alu_w_m(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input logic [2:0] opc);
    logic [15:0] c16;
    logic [15:0] r;
    c16 = {15'd0, cin};
    case (opc)
      3'd0:    r = a + b + c16;
      3'd1:    r = a - b - c16;
      3'd2:    r = a & b;
      3'd3:    r = a | b;
      3'd4:    r = a ^ b;
      3'd5:    r = {a[14:0], cin};
      3'd6:    r = {cin, a[15:1]};
      default: r = ~a;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] lfsr_at(input logic [31:0] seed, input int k);
    logic [31:0] l;
    l = (seed == 32'd0) ? 32'd1 : seed;
    for (int i = 0; i < k; i++) begin
      l = {l[30:0], 1'b0} ^ (l[31] ? 32'h0040_0007 : 32'h0000_0000);
    end
    return l;
  endfunction

  function automatic logic [15:0] fold(input logic [15:0] s, input logic [15:0] d);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ d;
  endfunction

  function automatic logic [15:0] resp(input logic [15:0] w, input logic zer, input logic neg);
    return w ^ {14'd0, neg, zer};
  endfunction

  function automatic logic [15:0] model_sig(input int n, input logic [31:0] seed, input logic stuck);
    logic [31:0] l;
    logic [15:0] s;
    logic [15:0] w;
    s = 16'd0;
    for (int i = 0; i < n; i++) begin
      l = lfsr_at(seed, i);
      w = alu_w_m(l[15:0], l[31:16], l[7], l[26:24]) | {15'd0, stuck};
      s = fold(s, resp(w, (w == 16'd0), w[15]));
    end
    return s;
  endfunction

  localparam logic [15:0] GOLD_A = model_sig(N_A, 32'h0000_0001, 1'b0);

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic        stuck_a = 1'b0;
  logic [15:0] a_alu_a, a_alu_b, a_alu_w, a_sig;
  logic        a_alu_cin, a_alu_zer, a_alu_neg, a_busy, a_done, a_pass;
  logic [2:0]  a_alu_opc;
  logic [15:0] b_alu_a, b_alu_b, b_sig;
  logic [15:0] b_alu_w = 16'd0;
  logic        b_alu_zer = 1'b0;
  logic        b_alu_neg = 1'b0;
  logic        b_alu_cin, b_busy, b_done, b_pass;
  logic [2:0]  b_alu_opc;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  assign a_alu_w   = alu_w_m(a_alu_a, a_alu_b, a_alu_cin, a_alu_opc) | {15'd0, stuck_a};
  assign a_alu_zer = (a_alu_w == 16'd0);
  assign a_alu_neg = a_alu_w[15];

  alu_bist_ctrl #(
    .NUM_VECTORS(N_A), .SETTLE_CYCLES(1), .SEED(32'h0000_0001), .GOLDEN_SIG(GOLD_A)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a),
    .alu_a(a_alu_a), .alu_b(a_alu_b), .alu_cin(a_alu_cin), .alu_opc(a_alu_opc),
    .alu_w(a_alu_w), .alu_zer(a_alu_zer), .alu_neg(a_alu_neg),
    .busy(a_busy), .done(a_done), .pass(a_pass), .signature(a_sig)
  );

  alu_bist_ctrl #(
    .NUM_VECTORS(N_B), .SETTLE_CYCLES(1), .SEED(32'h0000_0000), .GOLDEN_SIG(16'h0003)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b),
    .alu_a(b_alu_a), .alu_b(b_alu_b), .alu_cin(b_alu_cin), .alu_opc(b_alu_opc),
    .alu_w(b_alu_w), .alu_zer(b_alu_zer), .alu_neg(b_alu_neg),
    .busy(b_busy), .done(b_done), .pass(b_pass), .signature(b_sig)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_vec_a(input int k);
    logic [31:0] l;
    l = lfsr_at(32'h0000_0001, k);
    chk("a_vec_a", 32'(a_alu_a), 32'(l[15:0]));
    chk("a_vec_b", 32'(a_alu_b), 32'(l[31:16]));
    chk("a_vec_cin", 32'(a_alu_cin), 32'(l[7]));
    chk("a_vec_opc", 32'(a_alu_opc), 32'(l[26:24]));
  endtask

  // one full run of instance A; the start edge may already have happened (skip_start)
  task automatic run_a(input bit stuck, input bit noise, input bit hold_end, input bit skip_start);
    logic [15:0] exp_sig;
    stuck_a = stuck;
    exp_sig = model_sig(N_A, 32'h0000_0001, stuck);
    if (!skip_start) begin
      start_a = 1'b1;
      tick();
    end
    start_a = 1'b0;
    chk("a_busy_start", 32'(a_busy), 32'd1);
    chk("a_done_clr", 32'(a_done), 32'd0);
    for (int c = 1; c <= 3 * N_A; c++) begin
      start_a = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      if (c % 3 == 1) chk_vec_a((c - 1) / 3);
      if (c == 3 * N_A - 1) chk("a_len_done_low", 32'(a_done), 32'd0);
    end
    chk("a_done", 32'(a_done), 32'd1);
    chk("a_busy_end", 32'(a_busy), 32'd0);
    chk("a_sig", 32'(a_sig), 32'(exp_sig));
    chk("a_pass", 32'(a_pass), 32'(exp_sig == GOLD_A));
    start_a = hold_end;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] w0, w1, s_exp;
    logic        z0, z1, n0, n1;
    logic [31:0] l3;

    #2 rst_n = 1'b0;
    tick();
    tick();
    chk("rst_a_alu_a", 32'(a_alu_a), 32'd0);
    chk("rst_a_alu_b", 32'(a_alu_b), 32'd0);
    chk("rst_a_cin_opc", 32'({a_alu_cin, a_alu_opc}), 32'd0);
    chk("rst_a_flags", 32'({a_busy, a_done, a_pass}), 32'd0);
    chk("rst_a_sig", 32'(a_sig), 32'd0);
    chk("rst_b_flags", 32'({b_busy, b_done, b_pass}), 32'd0);
    rst_n = 1'b1;
    repeat (4) tick();
    chk("idle_busy", 32'(a_busy), 32'd0);
    chk("idle_alu_a", 32'(a_alu_a), 32'd0);

    // stub ALU returning w=0, zer=1: signature 0x0001 then 0x0003, zero seed acts as 1
    b_alu_w = 16'd0; b_alu_zer = 1'b1; b_alu_neg = 1'b0;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    tick();
    chk("b_vec0_a", 32'(b_alu_a), 32'h0001);
    chk("b_vec0_b", 32'(b_alu_b), 32'h0000);
    tick(); tick();
    chk("b_sig1", 32'(b_sig), 32'h0001);
    tick(); tick();
    chk("b_done_c5", 32'(b_done), 32'd0);
    tick();
    chk("b_done_c6", 32'(b_done), 32'd1);
    chk("b_pass_c6", 32'(b_pass), 32'd1);
    chk("b_sig2", 32'(b_sig), 32'h0003);

    // stub ALU with random responses
    for (int r = 0; r < 4; r++) begin
      w0 = 16'($urandom); w1 = 16'($urandom);
      z0 = 1'($urandom_range(0, 1)); z1 = 1'($urandom_range(0, 1));
      n0 = 1'($urandom_range(0, 1)); n1 = 1'($urandom_range(0, 1));
      if (r == 3) begin
        w0 = 16'd0; w1 = 16'd2; z0 = 1'b0; z1 = 1'b0; n0 = 1'b0; n1 = 1'b0;
      end
      s_exp = fold(16'd0, resp(w0, z0, n0));
      b_alu_w = w0; b_alu_zer = z0; b_alu_neg = n0;
      repeat ($urandom_range(1, 3)) tick();
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      tick(); tick(); tick();
      chk("b_rand_sig1", 32'(b_sig), 32'(s_exp));
      b_alu_w = w1; b_alu_zer = z1; b_alu_neg = n1;
      s_exp = fold(s_exp, resp(w1, z1, n1));
      tick(); tick(); tick();
      chk("b_rand_done", 32'(b_done), 32'd1);
      chk("b_rand_sig2", 32'(b_sig), 32'(s_exp));
      chk("b_rand_pass", 32'(b_pass), 32'(s_exp == 16'h0003));
    end

    // model ALU: golden run, run with start noise ending in held start, back-to-back run
    run_a(1'b0, 1'b0, 1'b0, 1'b0);
    repeat ($urandom_range(1, 3)) tick();
    run_a(1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    chk("b2b_done_1cyc", 32'(a_done), 32'd0);
    chk("b2b_busy", 32'(a_busy), 32'd1);
    run_a(1'b0, 1'b0, 1'b0, 1'b1);

    // result bit 0 stuck at 1
    repeat (2) tick();
    run_a(1'b1, 1'b0, 1'b0, 1'b0);
    chk("stuck_pass_low", 32'(a_pass), 32'd0);

    // reset during vector 3, then a clean run from the seed
    repeat (2) tick();
    stuck_a = 1'b0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (10) tick();
    l3 = lfsr_at(32'h0000_0001, 3);
    chk("mid_vec3_a", 32'(a_alu_a), 32'(l3[15:0]));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_alu", 32'({a_alu_a, a_alu_b}), 32'd0);
    chk("mid_rst_flags", 32'({a_busy, a_done, a_pass}), 32'd0);
    chk("mid_rst_sig", 32'(a_sig), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    run_a(1'b0, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
